// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, baud-rate table and the
// 16x oversampling divider helper used by both the transmitter and receiver.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    function automatic int unsigned baud_rate(input logic [2:0] code);
        case (code)
            3'b000:  return 300;
            3'b001:  return 1200;
            3'b010:  return 4800;
            3'b011:  return 9600;
            3'b100:  return 19200;
            3'b101:  return 38400;
            3'b110:  return 57600;
            default: return 115200;
        endcase
    endfunction

    // Rounded CLK_HZ / (16 * baud).
    function automatic int unsigned baud_divider(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// User/line-side signal bundle of the UART receiver. The receiver takes the
// slave view; the line driver and byte consumer take the master view.
interface uart_receiver_if;

    logic [2:0] baud_select;
    logic       RxD;
    logic       Rx_EN;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    modport master (
        output baud_select, RxD, Rx_EN,
        input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR
    );

    modport slave (
        input  baud_select, RxD, Rx_EN,
        output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR
    );

endinterface

// File: rtl/uart_receiver_baud_controller.sv
// Turns a 3-bit rate code into a one-clk 16x oversampling tick. A synchronous
// clear restarts the divider so ticks can be aligned to a start edge.
module baud_controller
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [2:0] baud_code,
    output logic       sample_tick
);

    localparam int unsigned Div0 = baud_divider(CLK_HZ, baud_rate(3'd0));
    localparam int unsigned Div1 = baud_divider(CLK_HZ, baud_rate(3'd1));
    localparam int unsigned Div2 = baud_divider(CLK_HZ, baud_rate(3'd2));
    localparam int unsigned Div3 = baud_divider(CLK_HZ, baud_rate(3'd3));
    localparam int unsigned Div4 = baud_divider(CLK_HZ, baud_rate(3'd4));
    localparam int unsigned Div5 = baud_divider(CLK_HZ, baud_rate(3'd5));
    localparam int unsigned Div6 = baud_divider(CLK_HZ, baud_rate(3'd6));
    localparam int unsigned Div7 = baud_divider(CLK_HZ, baud_rate(3'd7));
    // The slowest rate has the largest divider and sizes the counter.
    localparam int unsigned CntW = $clog2(Div0 + 1);

    logic [CntW-1:0] div_m1;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        case (baud_code)
            3'd0: div_m1 = CntW'(Div0 - 1);
            3'd1: div_m1 = CntW'(Div1 - 1);
            3'd2: div_m1 = CntW'(Div2 - 1);
            3'd3: div_m1 = CntW'(Div3 - 1);
            3'd4: div_m1 = CntW'(Div4 - 1);
            3'd5: div_m1 = CntW'(Div5 - 1);
            3'd6: div_m1 = CntW'(Div6 - 1);
            3'd7: div_m1 = CntW'(Div7 - 1);
        endcase
    end

    assign sample_tick = (cnt_q == div_m1);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear || sample_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 8E1 frames at a selectable 16x-oversampled rate.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote over ticks 6..8.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic           clk,
    input  logic           reset,
    uart_receiver_if.slave rx
);

    logic       rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [2:0] state_q, state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       perr_q, perr_d;
    logic [2:0] baud_q, baud_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       perror_q, perror_d;
    logic       ferror_q, ferror_d;

    logic       start_edge;
    logic       start_det;
    logic       sample_tick;
    logic       sample_now;
    logic       bit_val;
    logic       tick_wrap;

    baud_controller #(
        .CLK_HZ(CLK_HZ)
    ) u_baud_controller (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_det),
        .baud_code  (baud_q),
        .sample_tick(sample_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rx.RxD;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    assign start_edge = rxd_prev_q & ~rxd_sync_q;
    assign start_det  = (state_q == StIdle) && rx.Rx_EN && start_edge;
    assign tick_wrap  = sample_tick && (tick_cnt_q == 4'hf);

`ifdef UART_RX_MAJORITY_EN
    logic s6_q, s7_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s6_q <= 1'b1;
            s7_q <= 1'b1;
        end else if (sample_tick) begin
            if (tick_cnt_q == 4'd6) s6_q <= rxd_sync_q;
            if (tick_cnt_q == 4'd7) s7_q <= rxd_sync_q;
        end
    end

    // Vote at tick 8 so the bit boundaries stay where the single-sample build has them.
    assign sample_now = sample_tick && (tick_cnt_q == 4'd8);
    assign bit_val    = (s6_q & s7_q) | (s6_q & rxd_sync_q) | (s7_q & rxd_sync_q);
`else
    assign sample_now = sample_tick && (tick_cnt_q == 4'd7);
    assign bit_val    = rxd_sync_q;
`endif

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        baud_d     = baud_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perror_d   = perror_q;
        ferror_d   = ferror_q;

        if (sample_tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
        end

        if ((state_q != StIdle) && !rx.Rx_EN) begin
            state_d    = StIdle;
            tick_cnt_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    tick_cnt_d = '0;
                    if (start_det) begin
                        state_d  = StStart;
                        baud_d   = rx.baud_select;
                        perror_d = 1'b0;
                        ferror_d = 1'b0;
                    end
                end
                StStart: begin
                    if (sample_now && bit_val) begin
                        state_d    = StIdle;
                        tick_cnt_d = '0;
                    end else if (tick_wrap) begin
                        state_d    = StData;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
                StData: begin
                    if (sample_now) begin
                        shift_d = {bit_val, shift_q[7:1]};
                    end
                    if (tick_wrap) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = StParity;
                        end
                    end
                end
                StParity: begin
                    if (sample_now) begin
                        perr_d = bit_val ^ (^shift_q);
                    end
                    if (tick_wrap) begin
                        state_d    = StStop;
                        tick_cnt_d = '0;
                    end
                end
                StStop: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (sample_now) begin
                        data_d     = shift_q;
                        ferror_d   = ~bit_val;
                        perror_d   = perr_q;
                        valid_d    = bit_val & ~perr_q;
                        state_d    = StIdle;
                        tick_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = StIdle;
                    tick_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            baud_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perror_q   <= 1'b0;
            ferror_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            baud_q     <= baud_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perror_q   <= perror_d;
            ferror_q   <= ferror_d;
        end
    end

    assign rx.Rx_DATA   = data_q;
    assign rx.Rx_VALID  = valid_q;
    assign rx.Rx_PERROR = perror_q;
    assign rx.Rx_FERROR = ferror_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receive stage of the UART: it consumes the line driven by the transmitter and delivers bytes to the user side. Frame format: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1). Bit timing comes from a 16x oversampling tick generated from `baud_select` and the system clock. Reports data validity, parity errors and framing errors.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency in Hz; sets the divider table.
- `clk` in 1: system clock. All logic is in this single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `baud_select` in 3: rate select, sampled only at start-bit detection.
  - 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 baud.
- `RxD` in 1: serial line, asynchronous, idles high.
- `Rx_EN` in 1: receiver enable.
- `Rx_DATA` out 8: last completed frame's data.
- `Rx_VALID` out 1: one-cycle pulse when a frame is received with no error.
- `Rx_PERROR` out 1: parity mismatch flag.
- `Rx_FERROR` out 1: stop bit sampled as 0.

## Operation
- `RxD` passes through a 2-flop synchronizer (reset value 1) before any use.
- Tick generator:
  - Divider = round(CLK_HZ / (16 × baud)).
  - Emits a one-`clk` `sample_tick` at that rate.
  - Its counter is cleared on the IDLE→START transition, which aligns the ticks to the start edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Tick counter: 4-bit `tick_cnt`, cleared on every state entry, wraps modulo 16. A bit is sampled when `sample_tick` && `tick_cnt`==7 (mid-bit).
- Bit counter: 3-bit `bit_cnt` counts 0..7 in DATA.
- Transitions:
  - IDLE→START: `Rx_EN`=1 and a synced 1→0 edge on `RxD`. Latch `baud_select`. Clear both error flags.
  - START: if the mid-bit sample is 1 (glitch), go to IDLE with no outputs. Otherwise wait for `tick_cnt` to wrap, then go to DATA.
  - DATA: shift each mid-bit sample into bit 7 of the shift register, shifting right. After the 8th bit's 16 ticks, go to PARITY.
  - PARITY: the sample is XORed with XOR(data); a result of 1 means a parity error. After 16 ticks, go to STOP.
  - STOP: on the mid-bit sample:
    - `Rx_DATA` ← shift register.
    - `Rx_FERROR` ← (sample==0).
    - `Rx_PERROR` ← parity error.
    - `Rx_VALID` pulses only if both error flags are 0.
    - Return to IDLE on the same edge, so the next start bit can be detected half a bit early.
- `Rx_EN`=0 in any non-IDLE state: abort to IDLE on the next `clk`. Outputs are unchanged and no pulse is issued.
- `Rx_DATA` holds its value until the next completed frame. It is updated even on an error frame.
- Error flags hold until the next start detection. They are never set together with `Rx_VALID`.

## Timing
- Reset values: `Rx_DATA`=8'h00, `Rx_VALID`=0, `Rx_PERROR`=0, `Rx_FERROR`=0, FSM=IDLE, synchronizer=1, all counters 0.
- Reset asserted mid-frame: every register returns to its reset value immediately; no pulse is emitted.
- Latency: `Rx_VALID` rises (2 sync cycles + 10 bit times + 8 ticks) ±1 tick after the line's falling edge.
- `Rx_DATA`, `Rx_PERROR` and `Rx_FERROR` change on the same `clk` edge as the `Rx_VALID` pulse.
- A `baud_select` change mid-frame has no effect until the next frame.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each bit value is the 2-of-3 majority of the samples at `tick_cnt` 6, 7 and 8.
  - The bit is decided at `tick_cnt`==8, so state timing is unchanged.
  - The START glitch check also uses the majority.
- `UART_RX_MAJORITY_EN` undefined: single sample at `tick_cnt`==7.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding.
  - Baud-rate constants for codes 000–111.
  - Divider function of `CLK_HZ`, shared with the transmitter.
- One sub-module: `baud_controller` (baud select → 16x `sample_tick`, with a synchronous clear input).
- FSM, synchronizer and datapath stay in `uart_receiver`.

## Test plan
All scenarios use CLK_HZ=50_000_000.
- `baud_select`=111 (divider 27), send 8'hA5 with parity 0 and stop 1 → `Rx_DATA`=8'hA5, one `Rx_VALID` pulse, `Rx_PERROR`=`Rx_FERROR`=0.
- `baud_select`=011 (divider 326), send 8'h07 with parity bit 0 (wrong; correct is 1) → `Rx_PERROR`=1, `Rx_VALID` never high, `Rx_DATA`=8'h07.
- `baud_select`=111, send 8'h3C with stop bit 0 → `Rx_FERROR`=1, no `Rx_VALID`. The flag clears at the next start edge.
- `RxD` low pulse of 4 ticks while idle → return to IDLE, no outputs. The following frame 8'h55 is received correctly.
- Assert `reset` during DATA of frame 8'hFF → all outputs 0 immediately. Frame 8'h12 sent afterwards → `Rx_VALID` with `Rx_DATA`=8'h12.
- `Rx_EN`=0 mid-frame → no pulse. With `UART_RX_MAJORITY_EN` defined and a 1-tick inverting glitch at `tick_cnt`==7 of each data bit of 8'hC3 → still `Rx_DATA`=8'hC3 and `Rx_VALID`.
